// File: rtl/p1_multisum.sv
`timescale 1ns/1ps
// p1_multisum
// Sums every n in [1, Limit) that is a multiple of any (ModeAll=0) or all
// (ModeAll=1) of up to NDIV runtime-programmable divisors. Each divisor
// channel keeps a residue counter (n mod d_i) instead of a flag array, so
// storage grows with NDIV, not with Limit. One n is processed per cycle.
//
// Ports
//   CLK       in   clock, rising edge
//   RST_N     in   asynchronous active-low reset
//   Start     in   run request, accepted in IDLE or DONE
//   Limit     in   exclusive upper bound (NW bits), sampled on accepted Start
//   Divisors  in   packed divisors, channel i at [i*DW +: DW], 0 = disabled
//   ModeAll   in   0 = any enabled divisor, 1 = all enabled divisors
//   Busy      out  high while running
//   IsEnd     out  high when results are final
//   Sum       out  saturating sum of counted n (SW bits)
//   Count     out  number of counted n (NW bits)
//   Overflow  out  sticky, Sum saturated during this run
module p1_multisum #(
  parameter int NDIV = 2,
  parameter int DW   = 8,
  parameter int NW   = 16,
  parameter int SW   = 32
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 Start,
  input  logic [NW-1:0]        Limit,
  input  logic [NDIV*DW-1:0]   Divisors,
  input  logic                 ModeAll,
  output logic                 Busy,
  output logic                 IsEnd,
  output logic [SW-1:0]        Sum,
  output logic [NW-1:0]        Count,
  output logic                 Overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [NW-1:0]            limit_q, limit_d;
  logic [NDIV-1:0][DW-1:0]  div_q, div_d;
  logic [NDIV-1:0][DW-1:0]  res_q, res_d;
  logic                     mode_q, mode_d;
  logic [NW-1:0]            n_q, n_d;
  logic [SW-1:0]            sum_q, sum_d;
  logic [NW-1:0]            cnt_q, cnt_d;
  logic                     ovf_q, ovf_d;

  logic [NDIV-1:0]          en;
  logic [NDIV-1:0]          hit_ch;
  logic                     hit;
  logic                     accept;
  logic                     short_run;
  logic                     last_n;
  logic [SW:0]              add_res;

  // Saturating accumulate: returns {saturated, sum}. Once saturated the
  // result is pinned to all-ones for the remainder of the run.
  function automatic logic [SW:0] sat_add(input logic [SW-1:0] a,
                                          input logic [NW-1:0] b,
                                          input logic          sticky);
    logic [SW:0] t;
    t = {1'b0, a} + (SW+1)'(b);
    if (sticky || t[SW]) begin
      return {1'b1, {SW{1'b1}}};
    end
    return t;
  endfunction

  // Residue of n+1 given residue of n, wrapping at d-1.
  function automatic logic [DW-1:0] res_step(input logic [DW-1:0] r,
                                             input logic [DW-1:0] d);
    return (r == d - DW'(1)) ? '0 : r + DW'(1);
  endfunction

  // Residue of n = 1 for divisor d (1 mod 1 is 0).
  function automatic logic [DW-1:0] res_init(input logic [DW-1:0] d);
    return (d == DW'(1)) ? '0 : DW'(1);
  endfunction

  assign accept    = Start && (state_q != S_RUN);
  assign short_run = (Limit < NW'(2));
  assign last_n    = (n_q == limit_q - NW'(1));

  // Hit decision for the current n from the latched divisors/residues.
  always_comb begin
    en     = '0;
    hit_ch = '0;
    for (int i = 0; i < NDIV; i++) begin
      en[i]     = (div_q[i] != '0);
      hit_ch[i] = en[i] && (res_q[i] == '0);
    end
    // All mode ignores disabled channels but never hits with none enabled.
    hit = mode_q ? ((&(hit_ch | ~en)) && (|en)) : (|hit_ch);
  end

  // FSM: state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d = short_run ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last_n) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs are pure decodes of the registered state
  always_comb begin
    Busy  = (state_q == S_RUN);
    IsEnd = (state_q == S_DONE);
  end

  // Datapath next state
  always_comb begin
    limit_d = limit_q;
    div_d   = div_q;
    res_d   = res_q;
    mode_d  = mode_q;
    n_d     = n_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    add_res = sat_add(sum_q, n_q, ovf_q);

    if (accept) begin
      limit_d = Limit;
      div_d   = Divisors;
      mode_d  = ModeAll;
      n_d     = NW'(1);
      sum_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      for (int i = 0; i < NDIV; i++) begin
        res_d[i] = res_init(Divisors[i*DW +: DW]);
      end
    end else if (state_q == S_RUN) begin
      if (hit) begin
        sum_d = add_res[SW-1:0];
        ovf_d = add_res[SW];
        cnt_d = cnt_q + NW'(1);
      end
      for (int i = 0; i < NDIV; i++) begin
        if (en[i]) begin
          res_d[i] = res_step(res_q[i], div_q[i]);
        end
      end
      n_d = n_q + NW'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      limit_q <= '0;
      div_q   <= '0;
      res_q   <= '0;
      mode_q  <= 1'b0;
      n_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      limit_q <= limit_d;
      div_q   <= div_d;
      res_q   <= res_d;
      mode_q  <= mode_d;
      n_q     <= n_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Sum      = sum_q;
  assign Count    = cnt_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_p1_multisum.sv
`timescale 1ns/1ps
// Bench for p1_multisum: a 32-bit-sum instance and a 16-bit-sum instance
// share all inputs, so every run also exercises saturation behaviour.
module tb_p1_multisum;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        Start = 1'b0;
  logic        ModeAll = 1'b0;
  logic [15:0] Limit = '0;
  logic [15:0] Divisors = '0;

  logic        Busy, IsEnd, Overflow;
  logic [31:0] Sum;
  logic [15:0] Count;
  logic        Busy16, IsEnd16, Ovf16;
  logic [15:0] Sum16, Count16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  p1_multisum #(.NDIV(2), .DW(8), .NW(16), .SW(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .Start(Start), .Limit(Limit),
    .Divisors(Divisors), .ModeAll(ModeAll), .Busy(Busy), .IsEnd(IsEnd),
    .Sum(Sum), .Count(Count), .Overflow(Overflow)
  );

  p1_multisum #(.NDIV(2), .DW(8), .NW(16), .SW(16)) dut16 (
    .CLK(CLK), .RST_N(RST_N), .Start(Start), .Limit(Limit),
    .Divisors(Divisors), .ModeAll(ModeAll), .Busy(Busy16), .IsEnd(IsEnd16),
    .Sum(Sum16), .Count(Count16), .Overflow(Ovf16)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: direct enumeration of n with modulo tests.
  function automatic void model(input int L, input int d0, input int d1,
                                input bit mode, input int sw,
                                output longint s, output int c, output bit o);
    longint mx;
    bit h0, h1, h;
    mx = (longint'(1) << sw) - 1;
    s = 0; c = 0; o = 0;
    for (int n = 1; n < L; n++) begin
      h0 = (d0 != 0) ? ((n % d0) == 0) : 1'b0;
      h1 = (d1 != 0) ? ((n % d1) == 0) : 1'b0;
      if (mode) h = ((d0 != 0) || (d1 != 0)) && ((d0 == 0) || h0) && ((d1 == 0) || h1);
      else      h = h0 || h1;
      if (h) begin
        c++;
        s += n;
        if (s > mx) begin
          s = mx;
          o = 1'b1;
        end
      end
    end
  endfunction

  // One run from IDLE/DONE: handshake, latency, result clear, final results
  // of both instances against the model. 'disturb' fires a Start with other
  // inputs mid-run, which must be ignored.
  task automatic run(input string name, input int L, input int d0, input int d1,
                     input bit mode, input bit disturb);
    longint s32, s16;
    int     c32, c16, k;
    bit     o32, o16;
    model(L, d0, d1, mode, 32, s32, c32, o32);
    model(L, d0, d1, mode, 16, s16, c16, o16);
    @(negedge CLK);
    Limit    = 16'(L);
    Divisors = {8'(d1), 8'(d0)};
    ModeAll  = mode;
    Start    = 1'b1;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    check({name, ".clr_sum"}, Sum, 0);
    check({name, ".clr_cnt"}, Count, 0);
    check({name, ".busy0"}, Busy, (L >= 2) ? 1 : 0);
    check({name, ".isend0"}, IsEnd, (L >= 2) ? 0 : 1);
    k = 0;
    while (!IsEnd && k < 70000) begin
      if (disturb && k == 300) begin
        Start    = 1'b1;
        Limit    = 16'd5;
        Divisors = 16'h0207;
        ModeAll  = ~mode;
      end else if (disturb && k == 301) begin
        Start = 1'b0;
      end
      @(posedge CLK);
      #1;
      k++;
      if (Busy && IsEnd) check({name, ".excl"}, 1, 0);
    end
    Start = 1'b0;
    check({name, ".latency"}, k, (L >= 2) ? L - 1 : 0);
    check({name, ".sum"}, Sum, s32);
    check({name, ".cnt"}, Count, c32);
    check({name, ".ovf"}, Overflow, o32);
    check({name, ".sum16"}, Sum16, s16);
    check({name, ".cnt16"}, Count16, c16);
    check({name, ".ovf16"}, Ovf16, o16);
  endtask

  typedef struct {
    int     lim;
    int     d0;
    int     d1;
    bit     mode;
    longint s;
    int     c;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1000, 3, 5, 1'b0, 233168, 466};
    tbl[1]  = '{1000, 3, 5, 1'b1, 33165, 66};
    tbl[2]  = '{10,   3, 5, 1'b0, 23, 4};
    tbl[3]  = '{1,    3, 5, 1'b0, 0, 0};
    tbl[4]  = '{101,  1, 0, 1'b0, 5050, 100};
    tbl[5]  = '{101,  0, 0, 1'b0, 0, 0};
    tbl[6]  = '{101,  0, 0, 1'b1, 0, 0};
    tbl[7]  = '{0,    3, 5, 1'b0, 0, 0};
    tbl[8]  = '{2,    1, 1, 1'b1, 1, 1};
    tbl[9]  = '{16,   4, 6, 1'b1, 12, 1};
    tbl[10] = '{20,   2, 2, 1'b0, 90, 9};
    tbl[11] = '{20,   0, 7, 1'b1, 21, 2};

    // Reset state
    #1 RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst.busy", Busy, 0);
    check("rst.isend", IsEnd, 0);
    check("rst.sum", Sum, 0);
    check("rst.cnt", Count, 0);
    check("rst.ovf", Overflow, 0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Table vectors, back to back (each later run restarts from DONE)
    for (int i = 0; i < 12; i++) begin
      run($sformatf("tbl%0d", i), tbl[i].lim, tbl[i].d0, tbl[i].d1, tbl[i].mode, 1'b0);
      check($sformatf("tbl%0d.exp_sum", i), Sum, tbl[i].s);
      check($sformatf("tbl%0d.exp_cnt", i), Count, tbl[i].c);
      check($sformatf("tbl%0d.exp_ovf", i), Overflow, 0);
    end

    // 16-bit sum saturation
    run("sat", 1000, 1, 0, 1'b0, 1'b0);
    check("sat.sum16", Sum16, 65535);
    check("sat.ovf16", Ovf16, 1);
    check("sat.cnt16", Count16, 999);
    check("sat.sum32", Sum, 499500);

    // Asynchronous reset in the middle of a run
    @(negedge CLK);
    Limit = 16'd1000; Divisors = {8'd5, 8'd3}; ModeAll = 1'b0; Start = 1'b1;
    @(posedge CLK);
    #1 Start = 1'b0;
    repeat (500) @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    check("midrst.busy", Busy, 0);
    check("midrst.isend", IsEnd, 0);
    check("midrst.sum", Sum, 0);
    check("midrst.cnt", Count, 0);
    check("midrst.busy16", Busy16, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    check("midrst.idle_busy", Busy, 0);
    check("midrst.idle_isend", IsEnd, 0);

    // Start during RUN is ignored
    run("disturb", 1000, 3, 5, 1'b0, 1'b1);
    check("disturb.exp_sum", Sum, 233168);
    check("disturb.exp_cnt", Count, 466);

    // Randomized runs against the model
    for (int i = 0; i < 10; i++) begin
      run($sformatf("rnd%0d", i), int'($urandom_range(0, 300)),
          int'($urandom_range(0, 12)), int'($urandom_range(0, 12)),
          1'($urandom_range(0, 1)), 1'b0);
    end

    // DONE holds its results
    repeat (5) @(posedge CLK);
    #1;
    check("hold.isend", IsEnd, 1);
    check("hold.busy", Busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
